// File: rtl/alu_pkg.sv
// alu_pkg
//   Shared definitions for the sequential ALU family: operation codes,
//   the one-hot controller state encoding, and a helper that sizes the
//   iteration counter from the datapath width.
//   This file has no ports; alu_seq_n and its testbench import it.
package alu_pkg;

  // Operation select, sampled together with BEGIN
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  // One-hot controller states
  typedef enum logic [5:0] {
    IDLE   = 6'b000001,
    LOAD_B = 6'b000010,
    EXEC   = 6'b000100,
    ITER   = 6'b001000,
    OUT_HI = 6'b010000,
    OUT_LO = 6'b100000
  } aluStateT;

  // Counter must be able to hold the value W
  function automatic int ctrWidth(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/addsub_n.sv
// addsub_n
//   N-bit two's-complement adder/subtractor. This is the only arithmetic
//   unit of the ALU; EXEC, the Booth steps, the division steps and the
//   remainder correction all time-share it.
// Ports:
//   a_i     N  first operand
//   b_i     N  second operand
//   sub_i   1  1 = a_i - b_i, 0 = a_i + b_i
//   sum_o   N  result modulo 2^N
//   carry_o 1  carry out of bit N-1
//   ovf_o   1  signed overflow of the N-bit operation
module addsub_n #(
  parameter int N = 9
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         sub_i,
  output logic [N-1:0] sum_o,
  output logic         carry_o,
  output logic         ovf_o
);

  logic [N-1:0] bEff;
  logic [N:0]   full;

  // Subtraction is a + ~b + 1, the +1 entering as the carry-in
  assign bEff    = sub_i ? ~b_i : b_i;
  assign full    = {1'b0, a_i} + {1'b0, bEff} + {{N{1'b0}}, sub_i};
  assign sum_o   = full[N-1:0];
  assign carry_o = full[N];
  assign ovf_o   = (a_i[N-1] == bEff[N-1]) && (sum_o[N-1] != a_i[N-1]);

endmodule

// File: rtl/alu_seq_n.sv
// alu_seq_n
//   Parametrised sequential ALU: add, subtract, signed radix-2 Booth
//   multiply and unsigned non-restoring divide. Operand A arrives on inbus
//   with the BEGIN edge, operand B on the following edge. Results leave on
//   outbus qualified by END (one word for add/sub, high then low word for
//   mul/div).
// Ports:
//   clk      1  rising-edge clock
//   reset    1  asynchronous active-high reset
//   BEGIN    1  start request, sampled only in IDLE
//   op_code  2  operation select, sampled with BEGIN
//   inbus    W  operand bus (A, then B)
//   outbus   W  result word, zero while END=0
//   END      1  result-valid strobe
//   ovf      1  overflow / divide-by-zero flag, zero while END=0
module alu_seq_n
  import alu_pkg::*;
#(
  parameter int W  = 8,
  parameter int CW = ctrWidth(W)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         BEGIN,
  input  logic [1:0]   op_code,
  input  logic [W-1:0] inbus,
  output logic [W-1:0] outbus,
  output logic         END,
  output logic         ovf
);

  aluStateT      state_q;
  logic [1:0]    op_q;
  logic [W-1:0]  b_q;
  logic [W:0]    acc_q;
  logic [W-1:0]  qr_q;
  logic          qm1_q;
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  out_q;
  logic          end_q;
  logic          ovf_q;

  logic [W:0]    addA;
  logic [W:0]    addB;
  logic          addSub;
  logic [W:0]    addSum;
  logic          addOvf;
  logic          unusedCarry;

  logic [W:0]    boothAcc_d;
  logic [W-1:0]  boothQ_d;
  logic [W-1:0]  divQ_d;
  logic [W-1:0]  remainder_d;
  logic          mulOvf_d;
  logic          lastIter;

  addsub_n #(.N(W + 1)) uAddSub (
    .a_i     (addA),
    .b_i     (addB),
    .sub_i   (addSub),
    .sum_o   (addSum),
    .carry_o (unusedCarry),
    .ovf_o   (addOvf)
  );

  // Adder operand steering. In EXEC the operands are shifted up one bit so
  // the (W+1)-bit overflow flag equals the W-bit signed overflow. In ITER,
  // Booth works on the sign-extended accumulator, while division shifts the
  // next dividend bit in and adds or subtracts D according to the sign of
  // the partial remainder. OUT_HI reuses the idle adder to correct a
  // negative final remainder before it is presented in OUT_LO.
  always_comb begin
    addA   = '0;
    addB   = '0;
    addSub = 1'b0;
    unique case (state_q)
      EXEC: begin
        addA   = {qr_q, 1'b0};
        addB   = {b_q, 1'b0};
        addSub = (op_q == OP_SUB);
      end
      ITER: begin
        if (op_q == OP_MUL) begin
          addA = acc_q;
          unique case ({qr_q[0], qm1_q})
            2'b01:   addB = {b_q[W-1], b_q};
            2'b10: begin
              addB   = {b_q[W-1], b_q};
              addSub = 1'b1;
            end
            default: addB = '0;
          endcase
        end else begin
          addA   = {acc_q[W-1:0], qr_q[W-1]};
          addB   = {1'b0, b_q};
          addSub = ~acc_q[W];
        end
      end
      OUT_HI: begin
        addA = acc_q;
        addB = {1'b0, b_q};
      end
      default: ;
    endcase
  end

  // Next values for one iteration; Booth shifts {Acc, Q, Q-1} right
  // arithmetically, division shifts the quotient left taking the new bit
  // from the sign of the new partial remainder.
  assign boothAcc_d  = {addSum[W], addSum[W:1]};
  assign boothQ_d    = {addSum[0], qr_q[W-1:1]};
  assign divQ_d      = {qr_q[W-2:0], ~addSum[W]};
  assign remainder_d = acc_q[W] ? addSum[W-1:0] : acc_q[W-1:0];
  assign mulOvf_d    = (boothAcc_d[W-1:0] != {W{boothQ_d[W-1]}});
  assign lastIter    = (cnt_q == CW'(W - 1));

  // Controller, datapath registers and registered outputs. Outputs default
  // to zero every cycle and are loaded on the edge that enters OUT_HI or
  // OUT_LO, so END/outbus/ovf are purely registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      qr_q    <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      out_q   <= '0;
      end_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      out_q <= '0;
      end_q <= 1'b0;
      ovf_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (BEGIN) begin
            op_q    <= op_code;
            qr_q    <= inbus;
            state_q <= LOAD_B;
          end
        end
        LOAD_B: begin
          b_q   <= inbus;
          cnt_q <= '0;
          acc_q <= '0;
          qm1_q <= 1'b0;
          if (!op_q[1]) begin
            state_q <= EXEC;
          end else if ((op_q == OP_DIV) && (inbus == '0)) begin
            acc_q   <= {1'b0, qr_q};
            qr_q    <= '1;
            out_q   <= '1;
            end_q   <= 1'b1;
            ovf_q   <= 1'b1;
            state_q <= OUT_HI;
          end else begin
            state_q <= ITER;
          end
        end
        EXEC: begin
          out_q   <= addSum[W:1];
          end_q   <= 1'b1;
          ovf_q   <= addOvf;
          state_q <= OUT_LO;
        end
        ITER: begin
          cnt_q <= cnt_q + CW'(1);
          if (op_q == OP_MUL) begin
            acc_q <= boothAcc_d;
            qr_q  <= boothQ_d;
            qm1_q <= qr_q[0];
          end else begin
            acc_q <= addSum;
            qr_q  <= divQ_d;
          end
          if (lastIter) begin
            end_q   <= 1'b1;
            state_q <= OUT_HI;
            if (op_q == OP_MUL) begin
              out_q <= boothAcc_d[W-1:0];
              ovf_q <= mulOvf_d;
            end else begin
              out_q <= divQ_d;
            end
          end
        end
        OUT_HI: begin
          end_q   <= 1'b1;
          ovf_q   <= ovf_q;
          out_q   <= (op_q == OP_MUL) ? qr_q : remainder_d;
          state_q <= OUT_LO;
        end
        OUT_LO: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign outbus = out_q;
  assign END    = end_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_alu_seq_n.sv
// tb_alu_seq_n
//   Self-checking bench for alu_seq_n at W=8. Stimulus pushes the expected
//   result words (data, ovf, cycle of appearance) into a scoreboard; an
//   independent monitor pops and compares every cycle END is high, and
//   checks that outbus/ovf stay zero whenever END is low.
module tb_alu_seq_n;
  import alu_pkg::*;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] data;
    logic         ovf;
    int           cyc;
    string        name;
  } expT;

  logic         clk;
  logic         reset;
  logic         BEGIN;
  logic [1:0]   op_code;
  logic [W-1:0] inbus;
  logic [W-1:0] outbus;
  logic         END;
  logic         ovf;

  expT sbq[$];
  int  checks = 0;
  int  passes = 0;
  int  cyc    = 0;

  alu_seq_n #(.W(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .BEGIN   (BEGIN),
    .op_code (op_code),
    .inbus   (inbus),
    .outbus  (outbus),
    .END     (END),
    .ovf     (ovf)
  );

  // Free-running clock and edge counter used for latency checks
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Safety net so the run always terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached, required finish earlier");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  function automatic void pushExp(input logic [W-1:0] data, input logic ov,
                                  input int when, input string name);
    expT e;
    e.data = data;
    e.ovf  = ov;
    e.cyc  = when;
    e.name = name;
    sbq.push_back(e);
  endfunction

  // Monitor: sampled on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (END) begin
      if (sbq.size() == 0) begin
        checkOutput("unexpectedEnd", {31'b0, END}, 32'd0);
      end else begin
        expT e;
        e = sbq.pop_front();
        checkOutput({e.name, "Data"}, {24'b0, outbus}, {24'b0, e.data});
        checkOutput({e.name, "Ovf"}, {31'b0, ovf}, {31'b0, e.ovf});
        checkOutput({e.name, "Cycle"}, cyc, e.cyc);
      end
    end else begin
      checkOutput("idleZero", {23'b0, outbus, ovf}, 32'd0);
    end
  end

  // Issue one operation starting at the next rising edge (e0) and return at
  // the falling edge just before the earliest legal next start. With busy
  // set, BEGIN stays high and op_code/inbus churn while the ALU is working.
  task automatic applyStimulus(input logic [1:0] op, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic [W-1:0] hi,
                               input logic [W-1:0] lo, input logic ov,
                               input string name, input bit busy);
    int e0;
    int spacing;
    e0      = cyc + 1;
    BEGIN   = 1'b1;
    op_code = op;
    inbus   = a;
    if (!op[1]) begin
      spacing = 4;
      pushExp(lo, ov, e0 + 2, name);
    end else if ((op == OP_DIV) && (b == '0)) begin
      spacing = 4;
      pushExp(hi, ov, e0 + 1, {name, "Hi"});
      pushExp(lo, ov, e0 + 2, {name, "Lo"});
    end else begin
      spacing = W + 4;
      pushExp(hi, ov, e0 + W + 1, {name, "Hi"});
      pushExp(lo, ov, e0 + W + 2, {name, "Lo"});
    end
    @(negedge clk);
    inbus = b;
    BEGIN = busy;
    if (busy) op_code = ~op;
    for (int i = 2; i <= spacing; i++) begin
      @(negedge clk);
      if (busy) begin
        op_code = 2'(i);
        inbus   = W'(i * 37);
      end
    end
    BEGIN   = 1'b0;
    op_code = OP_ADD;
  endtask

  initial begin
    reset   = 1'b1;
    BEGIN   = 1'b0;
    op_code = OP_ADD;
    inbus   = '0;
    #12;
    checkOutput("resetEnd", {31'b0, END}, 32'd0);
    checkOutput("resetOutbus", {24'b0, outbus}, 32'd0);
    checkOutput("resetOvf", {31'b0, ovf}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Add / subtract
    applyStimulus(OP_ADD, 8'd56, 8'd89, 8'h00, 8'h91, 1'b1, "add56p89", 1'b0);
    applyStimulus(OP_ADD, 8'd20, 8'd30, 8'h00, 8'h32, 1'b0, "add20p30", 1'b0);
    applyStimulus(OP_SUB, 8'd56, 8'd89, 8'h00, 8'hDF, 1'b0, "sub56m89", 1'b0);
    applyStimulus(OP_SUB, 8'h80, 8'h01, 8'h00, 8'h7F, 1'b1, "sub80m01", 1'b0);

    // Multiply (signed)
    applyStimulus(OP_MUL, 8'd7, 8'd3, 8'h00, 8'h15, 1'b0, "mul7x3", 1'b0);
    applyStimulus(OP_MUL, 8'hF9, 8'd3, 8'hFF, 8'hEB, 1'b0, "mulm7x3", 1'b0);
    applyStimulus(OP_MUL, 8'd100, 8'd3, 8'h01, 8'h2C, 1'b1, "mul100x3", 1'b0);
    applyStimulus(OP_MUL, 8'h80, 8'hFF, 8'h00, 8'h80, 1'b1, "mulm128xm1", 1'b0);
    applyStimulus(OP_MUL, 8'hFD, 8'h80, 8'h01, 8'h80, 1'b1, "mulm3xm128", 1'b0);

    // Divide (unsigned)
    applyStimulus(OP_DIV, 8'd200, 8'd7, 8'h1C, 8'h04, 1'b0, "div200d7", 1'b0);
    applyStimulus(OP_DIV, 8'd200, 8'd0, 8'hFF, 8'hC8, 1'b1, "div200d0", 1'b0);
    applyStimulus(OP_DIV, 8'd255, 8'd1, 8'hFF, 8'h00, 1'b0, "div255d1", 1'b0);
    applyStimulus(OP_DIV, 8'd5, 8'd9, 8'h00, 8'h05, 1'b0, "div5d9", 1'b0);
    applyStimulus(OP_DIV, 8'd255, 8'd255, 8'h01, 8'h00, 1'b0, "div255d255", 1'b0);

    // BEGIN held high with churning op_code during a multiply; the next
    // operation must start on the first edge after IDLE is re-entered
    applyStimulus(OP_MUL, 8'd7, 8'd3, 8'h00, 8'h15, 1'b0, "mulBusy", 1'b1);
    applyStimulus(OP_ADD, 8'd1, 8'd1, 8'h00, 8'h02, 1'b0, "addAfterBusy", 1'b0);

    // Reset in the middle of an iterating multiply
    BEGIN   = 1'b1;
    op_code = OP_MUL;
    inbus   = 8'd7;
    @(negedge clk);
    inbus = 8'd3;
    BEGIN = 1'b0;
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("midResetEnd", {31'b0, END}, 32'd0);
    checkOutput("midResetOutbus", {24'b0, outbus}, 32'd0);
    checkOutput("midResetOvf", {31'b0, ovf}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    applyStimulus(OP_ADD, 8'd1, 8'd1, 8'h00, 8'h02, 1'b0, "addAfterReset", 1'b0);

    // Reset while a divide-by-zero result is being presented
    BEGIN   = 1'b1;
    op_code = OP_DIV;
    inbus   = 8'd200;
    @(negedge clk);
    inbus = 8'd0;
    BEGIN = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    checkOutput("outResetEnd", {31'b0, END}, 32'd0);
    checkOutput("outResetOutbus", {24'b0, outbus}, 32'd0);
    checkOutput("outResetOvf", {31'b0, ovf}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    applyStimulus(OP_ADD, 8'd20, 8'd30, 8'h00, 8'h32, 1'b0, "addAfterReset2", 1'b0);

    repeat (3) @(negedge clk);
    checkOutput("pendingResults", sbq.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
